// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_AW_DEF   = 4;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic {
    IDLE,
    ACCESS
  } ms_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_AW_DEF-1:0] wa3;
    logic                  regw;
    logic                  memw;
    logic                  load;
  } m_reg_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: access state, wait counter, stall and sticky error.
//
//   state  | meaning
//   IDLE   | M holds no aligned memory op; no request outstanding
//   ACCESS | M holds an aligned load/store; mem_req high until ack or timeout
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic capture_mem_i,
  input  logic m_misaligned_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic stall_o,
  output logic timeout_o,
  output logic err_o
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  ms_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign mem_req_o = (state_q == ACCESS);
  assign timeout_o = mem_req_o && !mem_ack_i && (cnt_q == CNT_W'(WAIT_MAX - 1));
  assign stall_o   = mem_req_o && !mem_ack_i && !timeout_o;
  assign err_o     = err_q;

  // The state follows whatever M captures on the same edge, so a memory op
  // released behind a finished access starts its own access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (m_misaligned_i || timeout_o) err_q <= 1'b1;
      if (!stall_o) begin
        state_q <= capture_mem_i ? ACCESS : IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: M/W pipeline registers, data-memory handshake and M-stage forwarding.
// The M register layout is fixed by mem_stage_pkg widths; DATA_W/REG_AW must match them.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_e,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              RegWE,
  input  logic              MemWE,
  input  logic              MemtoRegE,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o,
  output logic [DATA_W-1:0] fwd_result_m,
  output logic [REG_AW-1:0] fwd_wa3_m,
  output logic              fwd_regw_m,
  output logic [DATA_W-1:0] ResultW,
  output logic [REG_AW-1:0] WA3W,
  output logic              RegWriteW,
  output logic              err_o
);

  m_reg_t            m_d, m_q;
  logic [DATA_W-1:0] result_w_q;
  logic [REG_AW-1:0] wa3_w_q;
  logic              regw_w_q;
  logic              capture_mem;
  logic              m_misaligned;
  logic              timeout;

  assign capture_mem  = valid_e && (MemWE || MemtoRegE) && is_word_aligned(ALUResultE[1:0]);
  assign m_misaligned = (m_q.memw || m_q.load) && !is_word_aligned(m_q.result[1:0]);

  mem_req_fsm #(.WAIT_MAX(WAIT_MAX)) u_fsm (
    .clk            (clk),
    .rst            (rst),
    .capture_mem_i  (capture_mem),
    .m_misaligned_i (m_misaligned),
    .mem_ack_i      (mem_ack),
    .mem_req_o      (mem_req),
    .stall_o        (stall_o),
    .timeout_o      (timeout),
    .err_o          (err_o)
  );

  always_comb begin
    m_d        = '0;
    m_d.result = ALUResultE;
    m_d.wdata  = WriteDataE;
    m_d.wa3    = WA3E;
    m_d.regw   = valid_e & RegWE;
    m_d.memw   = valid_e & MemWE;
    m_d.load   = valid_e & MemtoRegE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          m_q <= '0;
    else if (!stall_o) m_q <= m_d;
  end

  // A misaligned or timed-out access retires as a bubble; stores never write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_w_q <= '0;
      wa3_w_q    <= '0;
      regw_w_q   <= 1'b0;
    end else if (stall_o) begin
      regw_w_q <= 1'b0;
    end else begin
      result_w_q <= (m_q.load && mem_req) ? mem_rdata : m_q.result;
      wa3_w_q    <= m_q.wa3;
      regw_w_q   <= m_q.regw & ~m_q.memw & ~m_misaligned & ~timeout;
    end
  end

  assign mem_we    = mem_req & m_q.memw;
  assign mem_addr  = mem_req ? {m_q.result[DATA_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? m_q.wdata : '0;

  assign fwd_result_m = m_q.result;
  assign fwd_wa3_m    = m_q.wa3;
  assign fwd_regw_m   = m_q.regw & ~m_q.load;

  assign ResultW   = result_w_q;
  assign WA3W      = wa3_w_q;
  assign RegWriteW = regw_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scenario bench for mem_access_stage; writebacks are scored against a queue of expected {WA3W, ResultW}.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_e = 1'b0;
  logic [31:0] ALUResultE = '0;
  logic [31:0] WriteDataE = '0;
  logic [3:0]  WA3E = '0;
  logic        RegWE = 1'b0;
  logic        MemWE = 1'b0;
  logic        MemtoRegE = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, stall_o, fwd_regw_m, RegWriteW, err_o;
  logic [31:0] mem_addr, mem_wdata, fwd_result_m, ResultW;
  logic [3:0]  fwd_wa3_m, WA3W;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_e;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .WA3E(WA3E), .RegWE(RegWE), .MemWE(MemWE),
    .MemtoRegE(MemtoRegE), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall_o(stall_o), .fwd_result_m(fwd_result_m),
    .fwd_wa3_m(fwd_wa3_m), .fwd_regw_m(fwd_regw_m), .ResultW(ResultW),
    .WA3W(WA3W), .RegWriteW(RegWriteW), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Every retired register write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && RegWriteW) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got WA3W=%0d ResultW=%h, expected no write", WA3W, ResultW);
      end else begin
        exp_e = exp_q.pop_front();
        if ({WA3W, ResultW} !== exp_e) begin
          errors++;
          $display("FAIL wb_value got WA3W=%0d ResultW=%h, expected WA3W=%0d ResultW=%h",
                   WA3W, ResultW, exp_e[35:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [3:0] wa, input logic rw, input logic mw, input logic ld);
    valid_e = v; ALUResultE = alu; WriteDataE = wd; WA3E = wa;
    RegWE = rw; MemWE = mw; MemtoRegE = ld;
  endtask

  task automatic bubble();
    drive_e(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    bubble();
    mem_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, stall_o, RegWriteW, err_o, fwd_regw_m} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got req/stall/regw/err/fwd=%b expected 00000",
               {mem_req, stall_o, RegWriteW, err_o, fwd_regw_m});
    end
    checks++;
    if ({ResultW, WA3W, fwd_result_m, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data got ResultW=%h WA3W=%0d fwd=%h addr=%h expected all 0",
               ResultW, WA3W, fwd_result_m, mem_addr);
    end
  endtask

  task automatic test_alu();
    step();
    drive_e(1'b1, 32'h0000_0010, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({4'd3, 32'h0000_0010});
    step();
    bubble();
    @(negedge clk);
    checks++;
    if ({fwd_result_m, fwd_wa3_m, fwd_regw_m} !== {32'h10, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL alu_fwd got %h/%0d/%b expected 00000010/3/1", fwd_result_m, fwd_wa3_m, fwd_regw_m);
    end
    checks++;
    if ({stall_o, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL alu_no_stall got stall=%b req=%b expected 0 0", stall_o, mem_req);
    end
    step();
    @(negedge clk);
    checks++;
    if ({RegWriteW, stall_o} !== 2'b10) begin
      errors++;
      $display("FAIL alu_wb got regw=%b stall=%b expected 1 0", RegWriteW, stall_o);
    end
  endtask

  task automatic test_load_zero_wait();
    step();
    drive_e(1'b1, 32'h0000_0100, 32'h0, 4'd5, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({4'd5, 32'hDEAD_BEEF});
    step();
    bubble();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, stall_o, fwd_regw_m} !== 4'b1000) begin
      errors++;
      $display("FAIL ld0_ctrl got req/we/stall/fwd=%b expected 1000", {mem_req, mem_we, stall_o, fwd_regw_m});
    end
    checks++;
    if (mem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL ld0_addr got %h expected 00000100", mem_addr);
    end
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({mem_req, RegWriteW} !== 2'b01) begin
      errors++;
      $display("FAIL ld0_done got req=%b regw=%b expected 0 1", mem_req, RegWriteW);
    end
  endtask

  task automatic test_store_wait();
    step();
    drive_e(1'b1, 32'h0000_0200, 32'h0000_1234, 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    drive_e(1'b1, 32'h0000_0055, 32'h0, 4'd7, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({4'd7, 32'h0000_0055});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, stall_o, RegWriteW} !== 4'b1110 ||
          mem_addr !== 32'h200 || mem_wdata !== 32'h1234) begin
        errors++;
        $display("FAIL st_wait%0d got req/we/stall/regw=%b addr=%h wdata=%h expected 1110 00000200 00001234",
                 i, {mem_req, mem_we, stall_o, RegWriteW}, mem_addr, mem_wdata);
      end
      step();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, stall_o} !== 3'b110 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL st_ack got req/we/stall=%b addr=%h expected 110 00000200",
               {mem_req, mem_we, stall_o}, mem_addr);
    end
    step();
    mem_ack = 1'b0;
    bubble();
    @(negedge clk);
    checks++;
    if ({fwd_result_m, fwd_wa3_m, RegWriteW, mem_req} !== {32'h55, 4'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL st_release got fwd=%h wa3=%0d regw=%b req=%b expected 00000055 7 0 0",
               fwd_result_m, fwd_wa3_m, RegWriteW, mem_req);
    end
    step();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_req;
    int n_stall;
    n_req = 0;
    n_stall = 0;
    step();
    drive_e(1'b1, 32'h0000_0300, 32'h0, 4'd9, 1'b1, 1'b0, 1'b1);
    step();
    bubble();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      n_req++;
      if (stall_o) n_stall++;
      step();
    end
    checks++;
    if (n_req != 15 || n_stall != 14) begin
      errors++;
      $display("FAIL to_cycles got req=%0d stall=%0d cycles expected 15 14", n_req, n_stall);
    end
    checks++;
    if ({err_o, RegWriteW, stall_o} !== 3'b100) begin
      errors++;
      $display("FAIL to_err got err/regw/stall=%b expected 100", {err_o, RegWriteW, stall_o});
    end
  endtask

  task automatic test_misaligned();
    step();
    drive_e(1'b1, 32'h0000_0102, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1);
    step();
    drive_e(1'b1, 32'h0000_0077, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({4'd8, 32'h0000_0077});
    @(negedge clk);
    checks++;
    if ({mem_req, stall_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL mis_noreq got req/stall/err=%b expected 000", {mem_req, stall_o, err_o});
    end
    step();
    bubble();
    @(negedge clk);
    checks++;
    if ({err_o, RegWriteW, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL mis_err got err/regw/req=%b expected 100", {err_o, RegWriteW, mem_req});
    end
    step();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    step();
    drive_e(1'b1, 32'h0000_0400, 32'h0, 4'd10, 1'b1, 1'b0, 1'b1);
    step();
    bubble();
    step();
    @(negedge clk);
    checks++;
    if ({mem_req, stall_o} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre got req/stall=%b expected 11", {mem_req, stall_o});
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, stall_o, RegWriteW, err_o, fwd_regw_m} !== 5'b0 ||
        {ResultW, WA3W, fwd_result_m, fwd_wa3_m, mem_addr} !== '0) begin
      errors++;
      $display("FAIL rst_async got req/stall/regw/err/fwd=%b ResultW=%h fwd=%h addr=%h expected all 0",
               {mem_req, stall_o, RegWriteW, err_o, fwd_regw_m}, ResultW, fwd_result_m, mem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_e(1'b1, 32'h0000_0500, 32'h0, 4'd11, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({4'd11, 32'hCAFE_F00D});
    step();
    bubble();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({mem_req, stall_o} !== 2'b10 || mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL rst_fresh got req/stall=%b addr=%h expected 10 00000500", {mem_req, stall_o}, mem_addr);
    end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({RegWriteW, err_o} !== 2'b10) begin
      errors++;
      $display("FAIL rst_fresh_wb got regw/err=%b expected 10", {RegWriteW, err_o});
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    apply_reset();
    test_misaligned();
    test_reset_mid_access();
    step();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending writebacks expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
